ysyx_24100029_axi_sram: RTL and testbench
=========================================

YSYX_24100029_AXI_SRAM -- requirements
Module: ysyx_24100029_axi_sram

Interface
REQ-001 Parameter ADDR_BASE, 32'h8000_0000, byte address of word 0.
REQ-002 Parameter DEPTH_WORDS, 4096, number of 32-bit words (power of two).
REQ-003 Parameter RD_LAT, 2, cycles from AR handshake to first rvalid (>=1).
REQ-004 Parameter WR_LAT, 1, cycles from last W beat to bvalid (>=1).
REQ-005 Ports: clock in 1, the single clock; reset in 1, synchronous active-high.
REQ-006 AW: awvalid in 1; awready out 1; awaddr in 32; awid in 4; awlen in 8; awsize in 3; awburst in 2.
REQ-007 W: wvalid in 1; wready out 1; wdata in 32; wstrb in 4; wlast in 1.
REQ-008 B: bvalid out 1; bready in 1; bresp out 2; bid out 4.
REQ-009 AR: arvalid in 1; arready out 1; araddr in 32; arid in 4; arlen in 8; arsize in 3; arburst in 2.
REQ-010 R: rvalid out 1; rready in 1; rdata out 32; rresp out 2; rlast out 1; rid out 4.

Function
REQ-011 Read and write channels SHALL run as independent FSMs; neither blocks the other.
REQ-012 Write FSM states: W_IDLE (awready=1), W_DATA (wready=1), W_WAIT (count WR_LAT), W_RESP (bvalid=1); transitions on AW handshake, W handshake with wlast, counter expiry, B handshake respectively.
REQ-013 W beats arriving before AW SHALL be stalled (wready=0 in W_IDLE).
REQ-014 Each W handshake SHALL write the bytes with wstrb[i]=1 to word (addr-ADDR_BASE)>>2 in the same cycle; wstrb=0 writes nothing.
REQ-015 Beat address: burst FIXED (2'b00) keeps address; INCR (2'b01) adds 1<<size per beat; WRAP treated as INCR.
REQ-016 Read FSM states: R_IDLE (arready=1), R_WAIT (count RD_LAT), R_DATA (rvalid=1); AR handshake -> R_WAIT; expiry -> R_DATA; each R handshake advances beat; handshake on beat arlen -> R_IDLE.
REQ-017 rlast SHALL be 1 exactly on beat arlen; rdata/rresp/rlast SHALL hold stable while rvalid=1 and rready=0.
REQ-018 rdata SHALL be the full aligned word; byte/half extraction is the master's job.
REQ-019 rid/bid SHALL echo the registered arid/awid.
REQ-020 Any beat whose address falls outside [ADDR_BASE, ADDR_BASE+4*DEPTH_WORDS) SHALL return SLVERR (2'b10): write dropped, rdata=0; bresp=SLVERR if any beat of the burst erred, else OKAY.
REQ-021 Same-cycle write and read-launch to one word: read returns pre-write data.
REQ-022 bvalid SHALL hold until bready; awready SHALL stay 0 until B handshake.
REQ-023 Unaligned addresses SHALL be word-aligned by dropping addr[1:0]; awsize/arsize >2 treated as 2.

Reset
REQ-024 On reset both FSMs SHALL go IDLE; awready=1, arready=1, wready=0, bvalid=0, rvalid=0, rlast=0, bresp=0, rresp=0, bid=0, rid=0, rdata=0.
REQ-025 Reset mid-burst SHALL abandon the transaction with no response; memory contents SHALL NOT be cleared.

Structure
REQ-026 Shared package SHALL hold AXI resp codes (OKAY, SLVERR), burst encodings and both FSM state enums.
REQ-027 Storage SHALL be sub-module ysyx_24100029_sram_array: DEPTH_WORDS x 32, one byte-enabled write port, one asynchronous read port.
REQ-028 Counters, beat address and beat-count registers SHALL live in ysyx_24100029_axi_sram.

Verification
REQ-029 Single write 0x8000_0010, wdata 0xDEADBEEF, wstrb 4'b1111, then read same -> bresp 0, bvalid WR_LAT cycles after W, rdata 0xDEADBEEF, rlast=1, rvalid RD_LAT cycles after AR.
REQ-030 Byte write 0x8000_0013, wdata 0xAB000000, wstrb 4'b1000 over 0x11223344 -> readback 0xAB223344.
REQ-031 INCR read arlen=3 from 0x8000_0000 with rready toggling 1,0,1,0 -> four beats in order, data stable while stalled, rlast only on fourth, rid=arid.
REQ-032 W presented 3 cycles before AW -> wready=0 until AW accepted; single write completes with bid=awid.
REQ-033 Read 0x7FFF_FFFC and write 0x8000_4000 (DEPTH 4096) -> rresp/bresp 2'b10, rdata 0, memory unchanged.
REQ-034 Reset asserted during R_DATA of arlen=7 burst -> next cycle rvalid=0, arready=1; prior written data still readable.

Source files
------------

// File: rtl/ysyx_24100029_axi_sram_pkg.sv
// Shared types and constants for the AXI SRAM slave: response codes, burst
// encodings, channel FSM states and the per-beat address step helper.
package ysyx_24100029_axi_sram_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_WAIT,
    W_RESP
  } wr_state_e;

  typedef enum logic [1:0] {
    R_IDLE,
    R_WAIT,
    R_DATA
  } rd_state_e;

  // Sizes wider than the 32-bit data bus step by a full word.
  function automatic logic [31:0] beat_step(input logic [2:0] size);
    logic [2:0] s;
    s = (size > 3'd2) ? 3'd2 : size;
    return 32'd1 << s;
  endfunction

endpackage

// File: rtl/ysyx_24100029_axi_sram_if.sv
// AXI4 bus bundle between a master and the SRAM slave (32-bit data, 4-bit IDs).
interface ysyx_24100029_axi_sram_if;

  logic        awvalid;
  logic        awready;
  logic [31:0] awaddr;
  logic [3:0]  awid;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;

  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;

  logic        bvalid;
  logic        bready;
  logic [1:0]  bresp;
  logic [3:0]  bid;

  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;

  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic [3:0]  rid;

  modport master (
    output awvalid, awaddr, awid, awlen, awsize, awburst,
    input  awready,
    output wvalid, wdata, wstrb, wlast,
    input  wready,
    input  bvalid, bresp, bid,
    output bready,
    output arvalid, araddr, arid, arlen, arsize, arburst,
    input  arready,
    input  rvalid, rdata, rresp, rlast, rid,
    output rready
  );

  modport slave (
    input  awvalid, awaddr, awid, awlen, awsize, awburst,
    output awready,
    input  wvalid, wdata, wstrb, wlast,
    output wready,
    output bvalid, bresp, bid,
    input  bready,
    input  arvalid, araddr, arid, arlen, arsize, arburst,
    output arready,
    output rvalid, rdata, rresp, rlast, rid,
    input  rready
  );

endinterface

// File: rtl/ysyx_24100029_sram_array.sv
// Word-organised storage: one byte-enabled synchronous write port and one
// asynchronous read port. Contents are never cleared.
module ysyx_24100029_sram_array #(
  parameter int DEPTH_WORDS = 4096
) (
  input  logic                           i_clock,
  input  logic                           i_we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] i_waddr,
  input  logic [31:0]                    i_wdata,
  input  logic [3:0]                     i_wstrb,
  input  logic [$clog2(DEPTH_WORDS)-1:0] i_raddr,
  output logic [31:0]                    o_rdata
);

  // One array per byte lane keeps each lane's write enable independent.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] r_lane [DEPTH_WORDS];

    always_ff @(posedge i_clock) begin
      if (i_we && i_wstrb[gi]) begin
        r_lane[i_waddr] <= i_wdata[gi*8 +: 8];
      end
    end

    assign o_rdata[gi*8 +: 8] = r_lane[i_raddr];
  end

endmodule

// File: rtl/ysyx_24100029_axi_sram.sv
// AXI4 SRAM slave with independent read and write channel FSMs, fixed
// response latencies and SLVERR for beats outside the mapped window.
module ysyx_24100029_axi_sram
  import ysyx_24100029_axi_sram_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
  parameter int          DEPTH_WORDS = 4096,
  parameter int          RD_LAT      = 2,
  parameter int          WR_LAT      = 1
) (
  input logic                     i_clock,
  input logic                     i_reset,
  ysyx_24100029_axi_sram_if.slave axi
);

  localparam int          AW      = $clog2(DEPTH_WORDS);
  localparam logic [15:0] WR_LOAD = 16'(WR_LAT - 1);
  localparam logic [15:0] RD_LOAD = 16'(RD_LAT - 1);

  function automatic logic in_range(input logic [31:0] a);
    return (a >= ADDR_BASE) && (((a - ADDR_BASE) >> 2) < 32'(DEPTH_WORDS));
  endfunction

  function automatic logic [AW-1:0] word_idx(input logic [31:0] a);
    return AW'((a - ADDR_BASE) >> 2);
  endfunction

  wr_state_e   r_wstate, w_wstate_next;
  logic [31:0] r_waddr;
  logic [3:0]  r_wid;
  logic [2:0]  r_wsize;
  logic [1:0]  r_wburst;
  logic        r_werr;
  logic [15:0] r_wcnt;
  logic        w_aw_hs, w_w_hs, w_we;

  rd_state_e   r_rstate, w_rstate_next;
  logic [31:0] r_raddr, w_raddr_adv, w_rd_addr;
  logic [3:0]  r_rid;
  logic [7:0]  r_rlen, r_rbeat;
  logic [2:0]  r_rsize;
  logic [1:0]  r_rburst;
  logic [15:0] r_rcnt;
  logic [31:0] r_rdata;
  logic [1:0]  r_rresp;
  logic        w_ar_hs, w_r_hs, w_rbeat_last, w_rload;

  logic [AW-1:0] w_waddr_idx, w_raddr_idx;
  logic [31:0]   w_mem_rdata;
  logic          w_unused_awlen;

  // Write bursts end on wlast, so awlen carries no information here.
  assign w_unused_awlen = ^axi.awlen;

  ysyx_24100029_sram_array #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_array (
    .i_clock (i_clock),
    .i_we    (w_we),
    .i_waddr (w_waddr_idx),
    .i_wdata (axi.wdata),
    .i_wstrb (axi.wstrb),
    .i_raddr (w_raddr_idx),
    .o_rdata (w_mem_rdata)
  );

  always_ff @(posedge i_clock) begin
    if (i_reset) r_wstate <= W_IDLE;
    else         r_wstate <= w_wstate_next;
  end

  always_comb begin
    w_wstate_next = r_wstate;
    axi.awready   = 1'b0;
    axi.wready    = 1'b0;
    axi.bvalid    = 1'b0;
    unique case (r_wstate)
      W_IDLE: begin
        axi.awready = 1'b1;
        if (axi.awvalid) w_wstate_next = W_DATA;
      end
      W_DATA: begin
        axi.wready = 1'b1;
        if (axi.wvalid && axi.wlast) w_wstate_next = (WR_LAT > 1) ? W_WAIT : W_RESP;
      end
      W_WAIT: begin
        if (r_wcnt <= 16'd1) w_wstate_next = W_RESP;
      end
      W_RESP: begin
        axi.bvalid = 1'b1;
        if (axi.bready) w_wstate_next = W_IDLE;
      end
      default: w_wstate_next = W_IDLE;
    endcase
  end

  assign w_aw_hs     = (r_wstate == W_IDLE) && axi.awvalid;
  assign w_w_hs      = (r_wstate == W_DATA) && axi.wvalid;
  assign w_we        = w_w_hs && in_range(r_waddr) && !i_reset;
  assign w_waddr_idx = word_idx(r_waddr);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_waddr  <= '0;
      r_wid    <= '0;
      r_wsize  <= '0;
      r_wburst <= '0;
      r_werr   <= 1'b0;
      r_wcnt   <= '0;
    end else begin
      if (w_aw_hs) begin
        r_waddr  <= axi.awaddr;
        r_wid    <= axi.awid;
        r_wsize  <= axi.awsize;
        r_wburst <= axi.awburst;
        r_werr   <= 1'b0;
      end
      if (w_w_hs) begin
        if (r_wburst != BURST_FIXED) r_waddr <= r_waddr + beat_step(r_wsize);
        if (!in_range(r_waddr))      r_werr  <= 1'b1;
        r_wcnt <= WR_LOAD;
      end else if (r_wstate == W_WAIT) begin
        r_wcnt <= r_wcnt - 16'd1;
      end
    end
  end

  assign axi.bresp = r_werr ? RESP_SLVERR : RESP_OKAY;
  assign axi.bid   = r_wid;

  always_ff @(posedge i_clock) begin
    if (i_reset) r_rstate <= R_IDLE;
    else         r_rstate <= w_rstate_next;
  end

  always_comb begin
    w_rstate_next = r_rstate;
    axi.arready   = 1'b0;
    axi.rvalid    = 1'b0;
    unique case (r_rstate)
      R_IDLE: begin
        axi.arready = 1'b1;
        if (axi.arvalid) w_rstate_next = (RD_LAT > 1) ? R_WAIT : R_DATA;
      end
      R_WAIT: begin
        if (r_rcnt <= 16'd1) w_rstate_next = R_DATA;
      end
      R_DATA: begin
        axi.rvalid = 1'b1;
        if (axi.rready && w_rbeat_last) w_rstate_next = R_IDLE;
      end
      default: w_rstate_next = R_IDLE;
    endcase
  end

  assign w_ar_hs      = (r_rstate == R_IDLE) && axi.arvalid;
  assign w_r_hs       = (r_rstate == R_DATA) && axi.rready;
  assign w_rbeat_last = (r_rbeat == r_rlen);
  assign w_raddr_adv  = (r_rburst == BURST_FIXED) ? r_raddr : (r_raddr + beat_step(r_rsize));

  // The output register is filled with the beat about to be presented, so a
  // write landing on the same edge is not yet visible to it.
  assign w_rd_addr = (r_rstate == R_IDLE) ? axi.araddr :
                     (r_rstate == R_DATA) ? w_raddr_adv : r_raddr;
  assign w_raddr_idx = word_idx(w_rd_addr);
  assign w_rload = (w_ar_hs && (RD_LAT == 1)) ||
                   ((r_rstate == R_WAIT) && (r_rcnt <= 16'd1)) ||
                   (w_r_hs && !w_rbeat_last);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_raddr  <= '0;
      r_rid    <= '0;
      r_rlen   <= '0;
      r_rbeat  <= '0;
      r_rsize  <= '0;
      r_rburst <= '0;
      r_rcnt   <= '0;
      r_rdata  <= '0;
      r_rresp  <= RESP_OKAY;
    end else begin
      if (w_ar_hs) begin
        r_raddr  <= axi.araddr;
        r_rid    <= axi.arid;
        r_rlen   <= axi.arlen;
        r_rbeat  <= '0;
        r_rsize  <= axi.arsize;
        r_rburst <= axi.arburst;
        r_rcnt   <= RD_LOAD;
      end else if (r_rstate == R_WAIT) begin
        r_rcnt <= r_rcnt - 16'd1;
      end
      if (w_r_hs && !w_rbeat_last) begin
        r_raddr <= w_raddr_adv;
        r_rbeat <= r_rbeat + 8'd1;
      end
      if (w_rload) begin
        r_rdata <= in_range(w_rd_addr) ? w_mem_rdata : 32'd0;
        r_rresp <= in_range(w_rd_addr) ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  assign axi.rdata = r_rdata;
  assign axi.rresp = r_rresp;
  assign axi.rlast = (r_rstate == R_DATA) && w_rbeat_last;
  assign axi.rid   = r_rid;

endmodule

// File: tb/tb_ysyx_24100029_axi_sram.sv
// Scoreboard bench for the AXI SRAM slave: tasks push expected responses from
// a word-array reference model, a monitor pops and compares on each handshake.
module tb_ysyx_24100029_axi_sram;

  localparam logic [31:0] BASE   = 32'h8000_0000;
  localparam int          DEPTH  = 4096;
  localparam int          RD_LAT = 2;
  localparam int          WR_LAT = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ysyx_24100029_axi_sram_if bus ();

  ysyx_24100029_axi_sram #(
    .ADDR_BASE   (BASE),
    .DEPTH_WORDS (DEPTH),
    .RD_LAT      (RD_LAT),
    .WR_LAT      (WR_LAT)
  ) dut (
    .i_clock (clk),
    .i_reset (rst),
    .axi     (bus)
  );

  typedef struct { logic [31:0] data; logic [1:0] resp; logic last; logic [3:0] id; } r_exp_t;
  typedef struct { logic [1:0] resp; logic [3:0] id; } b_exp_t;

  r_exp_t      exp_r [$];
  b_exp_t      exp_b [$];
  logic [31:0] mdl [DEPTH];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: handshake did not occur within the cycle budget", name);
  endtask

  function automatic bit m_in_range(input logic [31:0] a);
    longint ua, lo;
    ua = longint'({32'b0, a});
    lo = longint'({32'b0, BASE});
    return (ua >= lo) && (ua < lo + 4 * DEPTH);
  endfunction

  function automatic int m_word(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  function automatic logic [31:0] m_beat(input logic [31:0] a, input int k,
                                         input logic [2:0] size, input logic [1:0] burst);
    int step;
    step = 1 << ((size > 3'd2) ? 2 : int'(size));
    return (burst == 2'b00) ? a : a + 32'(k * step);
  endfunction

  task automatic axi_write(input logic [31:0] addr, input logic [3:0] id, input int len,
                           input logic [2:0] size, input logic [1:0] burst,
                           input logic [31:0] data [$], input logic [3:0] strb [$],
                           input int early, input int bdly);
    bit          err, ok;
    int          lat;
    logic [31:0] a;
    b_exp_t      e;
    err = 1'b0;
    for (int k = 0; k <= len; k++) begin
      a = m_beat(addr, k, size, burst);
      if (m_in_range(a)) begin
        for (int b = 0; b < 4; b++)
          if (strb[k][b]) mdl[m_word(a)][b*8 +: 8] = data[k][b*8 +: 8];
      end else err = 1'b1;
    end
    e.resp = err ? 2'b10 : 2'b00;
    e.id   = id;
    exp_b.push_back(e);
    if (early > 0) begin
      bus.wvalid = 1'b1; bus.wdata = data[0]; bus.wstrb = strb[0]; bus.wlast = (len == 0);
      repeat (early) begin
        @(negedge clk); chk("wready_before_aw", 32'(bus.wready), 32'd0);
        @(posedge clk); #1;
      end
    end
    bus.awvalid = 1'b1; bus.awaddr = addr; bus.awid = id; bus.awlen = 8'(len);
    bus.awsize = size; bus.awburst = burst;
    ok = 1'b0;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(negedge clk); if (bus.awready) ok = 1'b1;
      @(posedge clk); #1;
    end
    bus.awvalid = 1'b0;
    if (!ok) timeout("aw_handshake");
    for (int k = 0; k <= len; k++) begin
      bus.wvalid = 1'b1; bus.wdata = data[k]; bus.wstrb = strb[k]; bus.wlast = (k == len);
      ok = 1'b0;
      for (int c = 0; c < 50 && !ok; c++) begin
        @(negedge clk); if (bus.wready) ok = 1'b1;
        @(posedge clk); #1;
      end
      if (!ok) timeout("w_handshake");
    end
    bus.wvalid = 1'b0; bus.wlast = 1'b0;
    lat = 0; ok = 1'b0;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(negedge clk); lat++;
      if (bus.bvalid) ok = 1'b1;
      else begin @(posedge clk); #1; end
    end
    if (!ok) timeout("bvalid_wait");
    else chk("b_latency", 32'(lat), 32'(WR_LAT));
    repeat (bdly) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("bvalid_hold", 32'(bus.bvalid), 32'd1);
      chk("awready_low_in_resp", 32'(bus.awready), 32'd0);
    end
    @(posedge clk); #1; bus.bready = 1'b1;
    @(posedge clk); #1; bus.bready = 1'b0;
  endtask

  // mode: 0 rready held high, 1 toggles 1,0,1,0..., 2 random.
  task automatic axi_read(input logic [31:0] addr, input logic [3:0] id, input int len,
                          input logic [2:0] size, input logic [1:0] burst,
                          input int mode, input int abort_after);
    bit          ok;
    int          lat, beats, cyc;
    logic [31:0] a;
    r_exp_t      e;
    for (int k = 0; k <= len; k++) begin
      a      = m_beat(addr, k, size, burst);
      e.data = m_in_range(a) ? mdl[m_word(a)] : 32'd0;
      e.resp = m_in_range(a) ? 2'b00 : 2'b10;
      e.last = (k == len);
      e.id   = id;
      exp_r.push_back(e);
    end
    bus.arvalid = 1'b1; bus.araddr = addr; bus.arid = id; bus.arlen = 8'(len);
    bus.arsize = size; bus.arburst = burst;
    ok = 1'b0;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(negedge clk); if (bus.arready) ok = 1'b1;
      @(posedge clk); #1;
    end
    bus.arvalid = 1'b0;
    if (!ok) timeout("ar_handshake");
    lat = 0; ok = 1'b0;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(negedge clk); lat++;
      if (bus.rvalid) ok = 1'b1;
      else begin @(posedge clk); #1; end
    end
    if (!ok) timeout("rvalid_wait");
    else chk("r_latency", 32'(lat), 32'(RD_LAT));
    beats = 0; cyc = 0;
    while (beats <= len && cyc < 400) begin
      @(posedge clk); #1;
      if (abort_after >= 0 && beats == abort_after) break;
      case (mode)
        0:       bus.rready = 1'b1;
        1:       bus.rready = (cyc % 2 == 0);
        default: bus.rready = 1'($urandom_range(0, 1));
      endcase
      cyc++;
      @(negedge clk);
      if (bus.rvalid && bus.rready) beats++;
    end
    if (abort_after >= 0) begin
      bus.rready = 1'b0;
      rst = 1'b1;
      repeat (len + 1 - beats) void'(exp_r.pop_back());
      @(posedge clk); #1; rst = 1'b0;
      @(negedge clk);
      chk("rvalid_after_reset", 32'(bus.rvalid), 32'd0);
      chk("arready_after_reset", 32'(bus.arready), 32'd1);
      chk("rlast_after_reset", 32'(bus.rlast), 32'd0);
    end else begin
      if (beats <= len) timeout("r_beats");
      @(posedge clk); #1; bus.rready = 1'b0;
      @(negedge clk);
      chk("rvalid_after_last", 32'(bus.rvalid), 32'd0);
    end
    @(posedge clk); #1;
  endtask

  // Monitor: pops expectations on each handshake and checks R stability on stalls.
  initial begin
    logic        stalled;
    logic [31:0] s_data;
    logic [1:0]  s_resp;
    logic        s_last;
    r_exp_t      er;
    b_exp_t      eb;
    stalled = 1'b0; s_data = '0; s_resp = '0; s_last = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          chk("rvalid_hold", 32'(bus.rvalid), 32'd1);
          chk("rdata_stable", bus.rdata, s_data);
          chk("rresp_stable", 32'(bus.rresp), 32'(s_resp));
          chk("rlast_stable", 32'(bus.rlast), 32'(s_last));
        end
        stalled = bus.rvalid && !bus.rready;
        s_data = bus.rdata; s_resp = bus.rresp; s_last = bus.rlast;
        if (bus.rvalid && bus.rready) begin
          if (exp_r.size() == 0) timeout("unexpected_r_beat");
          else begin
            er = exp_r.pop_front();
            chk("rdata", bus.rdata, er.data);
            chk("rresp", 32'(bus.rresp), 32'(er.resp));
            chk("rlast", 32'(bus.rlast), 32'(er.last));
            chk("rid", 32'(bus.rid), 32'(er.id));
          end
        end
        if (bus.bvalid && bus.bready) begin
          if (exp_b.size() == 0) timeout("unexpected_b");
          else begin
            eb = exp_b.pop_front();
            chk("bresp", 32'(bus.bresp), 32'(eb.resp));
            chk("bid", 32'(bus.bid), 32'(eb.id));
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] dq [$];
    logic [3:0]  sq [$];
    logic [31:0] addr;
    int          len, sel;

    bus.awvalid = 0; bus.awaddr = 0; bus.awid = 0; bus.awlen = 0; bus.awsize = 0; bus.awburst = 0;
    bus.wvalid = 0; bus.wdata = 0; bus.wstrb = 0; bus.wlast = 0; bus.bready = 0;
    bus.arvalid = 0; bus.araddr = 0; bus.arid = 0; bus.arlen = 0; bus.arsize = 0; bus.arburst = 0;
    bus.rready = 0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_awready", 32'(bus.awready), 32'd1);
    chk("rst_arready", 32'(bus.arready), 32'd1);
    chk("rst_wready", 32'(bus.wready), 32'd0);
    chk("rst_bvalid", 32'(bus.bvalid), 32'd0);
    chk("rst_rvalid", 32'(bus.rvalid), 32'd0);
    chk("rst_rlast", 32'(bus.rlast), 32'd0);
    chk("rst_bresp", 32'(bus.bresp), 32'd0);
    chk("rst_rresp", 32'(bus.rresp), 32'd0);
    chk("rst_bid", 32'(bus.bid), 32'd0);
    chk("rst_rid", 32'(bus.rid), 32'd0);
    chk("rst_rdata", bus.rdata, 32'd0);
    @(posedge clk); #1; rst = 1'b0;

    // Single full-word write then read.
    dq = '{32'hDEAD_BEEF}; sq = '{4'b1111};
    axi_write(32'h8000_0010, 4'h3, 0, 3'd2, 2'b01, dq, sq, 0, 0);
    axi_read(32'h8000_0010, 4'h5, 0, 3'd2, 2'b01, 0, -1);

    // Byte-lane write over a known word.
    dq = '{32'h1122_3344}; sq = '{4'b1111};
    axi_write(32'h8000_0010, 4'h1, 0, 3'd2, 2'b01, dq, sq, 0, 2);
    dq = '{32'hAB00_0000}; sq = '{4'b1000};
    axi_write(32'h8000_0013, 4'h2, 0, 3'd0, 2'b01, dq, sq, 0, 1);
    axi_read(32'h8000_0010, 4'h6, 0, 3'd2, 2'b01, 0, -1);

    // Fill the windows used by the random phase.
    dq.delete(); sq.delete();
    for (int k = 0; k < 40; k++) begin dq.push_back($urandom); sq.push_back(4'hF); end
    axi_write(BASE, 4'h7, 39, 3'd2, 2'b01, dq, sq, 0, 0);
    dq.delete(); sq.delete();
    for (int k = 0; k < 8; k++) begin dq.push_back($urandom); sq.push_back(4'hF); end
    axi_write(BASE + 32'(4 * 4088), 4'h8, 7, 3'd2, 2'b01, dq, sq, 0, 0);

    // Four-beat INCR read with rready toggling.
    axi_read(BASE, 4'h9, 3, 3'd2, 2'b01, 1, -1);

    // W presented before AW.
    dq = '{32'hCAFE_F00D}; sq = '{4'b1111};
    axi_write(32'h8000_0020, 4'hA, 0, 3'd2, 2'b01, dq, sq, 3, 0);
    axi_read(32'h8000_0020, 4'hB, 0, 3'd2, 2'b01, 0, -1);

    // Out-of-window accesses on both sides.
    axi_read(32'h7FFF_FFFC, 4'hC, 0, 3'd2, 2'b01, 0, -1);
    dq = '{32'h5555_AAAA}; sq = '{4'b1111};
    axi_write(32'h8000_4000, 4'hD, 0, 3'd2, 2'b01, dq, sq, 0, 0);
    axi_read(BASE, 4'hE, 0, 3'd2, 2'b01, 0, -1);
    axi_read(32'h8000_3FFC, 4'hF, 0, 3'd2, 2'b01, 0, -1);

    // Read and write channels in flight together on disjoint words.
    dq.delete(); sq.delete();
    for (int k = 0; k < 4; k++) begin dq.push_back($urandom); sq.push_back(4'hF); end
    fork
      axi_write(BASE + 32'(4 * 50), 4'h4, 3, 3'd2, 2'b01, dq, sq, 0, 1);
      axi_read(BASE, 4'h2, 3, 3'd2, 2'b01, 2, -1);
    join
    axi_read(BASE + 32'(4 * 50), 4'h3, 3, 3'd2, 2'b01, 0, -1);

    // Randomised mix of bursts, sizes, strobes and boundary addresses.
    for (int t = 0; t < 40; t++) begin
      sel = $urandom_range(0, 9);
      if (sel < 7)      addr = BASE + 32'(4 * $urandom_range(0, 31)) + 32'($urandom_range(0, 3));
      else if (sel < 9) addr = BASE + 32'(4 * $urandom_range(4092, 4095)) + 32'($urandom_range(0, 3));
      else              addr = BASE - 32'(4 * $urandom_range(1, 2));
      len = $urandom_range(0, 7);
      if ($urandom_range(0, 1) == 1) begin
        dq.delete(); sq.delete();
        for (int k = 0; k <= len; k++) begin
          dq.push_back($urandom); sq.push_back(4'($urandom_range(0, 15)));
        end
        axi_write(addr, 4'($urandom_range(0, 15)), len, 3'($urandom_range(0, 3)),
                  2'($urandom_range(0, 2)), dq, sq, $urandom_range(0, 1), $urandom_range(0, 2));
      end else begin
        axi_read(addr, 4'($urandom_range(0, 15)), len, 3'($urandom_range(0, 3)),
                 2'($urandom_range(0, 2)), 2, -1);
      end
    end

    // Reset in the middle of an eight-beat read; memory must survive.
    dq.delete(); sq.delete();
    for (int k = 0; k < 8; k++) begin dq.push_back($urandom); sq.push_back(4'hF); end
    axi_write(BASE + 32'(4 * 100), 4'h6, 7, 3'd2, 2'b01, dq, sq, 0, 0);
    axi_read(BASE + 32'(4 * 100), 4'h7, 7, 3'd2, 2'b01, 0, 3);
    axi_read(BASE + 32'(4 * 100), 4'h8, 7, 3'd2, 2'b01, 2, -1);

    repeat (5) @(posedge clk);
    #1;
    chk("r_queue_drained", 32'(exp_r.size()), 32'd0);
    chk("b_queue_drained", 32'(exp_b.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
